// File: rtl/tmon_master_if.sv
// rtl/tmon_master_if.sv - temperature-monitor bus bundle shared by initiator and responder

interface tmon_if #(
    parameter type DTYPE = logic [7:0]
) ();
    // status encoding: 0 OK, 1 HIGH, 2 LOW
    logic [3:0] op;
    DTYPE       opnd;
    logic       ready;
    logic       valid;
    DTYPE       data;
    logic [1:0] status;

    modport master (
        output op,
        output opnd,
        input  ready,
        input  valid,
        input  data,
        input  status
    );

    modport slave (
        input  op,
        input  opnd,
        output ready,
        output valid,
        output data,
        output status
    );
endinterface

// File: rtl/tmon_master.sv
// rtl/tmon_master.sv - single-outstanding-command initiator for the temperature-monitor bus

module tmon_master #(
    parameter type DTYPE   = logic [7:0],
    parameter int  TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    tmon_if.master     tmon_bus,
    input  logic       req_valid,
    input  logic [3:0] req_op,
    input  DTYPE       req_opnd,
    output logic       req_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output DTYPE       rsp_data,
    output logic       rsp_err,
    input  logic       clr_alarm,
    output logic       alarm_high,
    output logic       alarm_low
);

    // Wait counter must be able to hold TIMEOUT: it steps once more on the exit cycle.
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [3:0] OP_RESET = 4'd0;
    localparam logic [3:0] OP_NOOP  = 4'b1000;

    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_RDY  = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_DATA = 3'd3;
    localparam logic [2:0] S_RESP      = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    op_q;
    DTYPE          opnd_q;

    logic is_read;
    logic at_last;
    logic rdy_timeout;
    logic data_timeout;
    logic rsp_done;
    logic alarm_clr;
    logic cnt_clear;

    // Opcodes 4..7 return data; everything else (including NOOPs) completes after ISSUE.
    assign is_read      = (op_q[3:2] == 2'b01);
    assign at_last      = (wait_cnt == CNT_LAST);
    assign rdy_timeout  = (state == S_WAIT_RDY)  && at_last && !tmon_bus.ready;
    assign data_timeout = (state == S_WAIT_DATA) && at_last && !tmon_bus.valid;
    assign rsp_done     = (state == S_RESP) && rsp_ready;

    // A RESET that really reached the responder also wipes the alarms when the host takes it.
    assign alarm_clr = clr_alarm || (rsp_done && (op_q == OP_RESET) && !rsp_err);

    // The counter restarts whenever either wait state is freshly entered.
    assign cnt_clear = ((state_nxt == S_WAIT_RDY)  && (state != S_WAIT_RDY)) ||
                       ((state_nxt == S_WAIT_DATA) && (state != S_WAIT_DATA));

    // Next-state decode; the awaited signal beats the timeout in the last counted cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    state_nxt = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (tmon_bus.ready) begin
                    state_nxt = S_ISSUE;
                end else if (at_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_ISSUE: begin
                state_nxt = is_read ? S_WAIT_DATA : S_RESP;
            end
            S_WAIT_DATA: begin
                if (tmon_bus.valid || at_last) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight command without a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cycle counter for the ready/valid waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (cnt_clear) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT_RDY) || (state == S_WAIT_DATA)) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    // Command capture at accept time so the host may change its request lines afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= OP_NOOP;
            opnd_q <= '0;
        end else if ((state == S_IDLE) && req_valid) begin
            op_q   <= req_op;
            opnd_q <= req_opnd;
        end
    end

    // Response payload: zeroed at accept, filled by returned data or flagged on timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if ((state == S_IDLE) && req_valid) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (rdy_timeout || data_timeout) begin
            rsp_err  <= 1'b1;
        end else if ((state == S_WAIT_DATA) && tmon_bus.valid) begin
            rsp_data <= tmon_bus.data;
        end
    end

    // Sticky alarms; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_high <= 1'b0;
            alarm_low  <= 1'b0;
        end else begin
            alarm_high <= (alarm_high && !alarm_clr) || (tmon_bus.status == ST_HIGH);
            alarm_low  <= (alarm_low  && !alarm_clr) || (tmon_bus.status == ST_LOW);
        end
    end

    // Host handshake and bus drive decode from state and latched command only.
    assign req_ready     = (state == S_IDLE);
    assign rsp_valid     = (state == S_RESP);
    assign tmon_bus.op   = (state == S_ISSUE) ? op_q   : OP_NOOP;
    assign tmon_bus.opnd = (state == S_ISSUE) ? opnd_q : DTYPE'(0);

endmodule

// File: tb/tb_tmon_master.sv
// tb/tb_tmon_master.sv - self-checking bench for tmon_master (TIMEOUT=255 and TIMEOUT=4 instances)

module tb_tmon_master;

    localparam int T0 = 255;
    localparam int T1 = 4;
    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       req_valid [2];
    logic [3:0] req_op    [2];
    logic [7:0] req_opnd  [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [7:0] rsp_data  [2];
    logic       rsp_err   [2];
    logic       clr_alarm [2];
    logic       alarm_high[2];
    logic       alarm_low [2];
    logic       ready     [2];
    logic       valid     [2];
    logic [7:0] data      [2];
    logic [1:0] status    [2];
    logic [3:0] op_o      [2];
    logic [7:0] opnd_o    [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tmon_if bus ();
        assign bus.ready  = ready[g];
        assign bus.valid  = valid[g];
        assign bus.data   = data[g];
        assign bus.status = status[g];
        assign op_o[g]    = bus.op;
        assign opnd_o[g]  = bus.opnd;

        tmon_master #(.DTYPE(logic [7:0]), .TIMEOUT(g == 0 ? T0 : T1)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .tmon_bus  (bus),
            .req_valid (req_valid[g]),
            .req_op    (req_op[g]),
            .req_opnd  (req_opnd[g]),
            .req_ready (req_ready[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_err   (rsp_err[g]),
            .clr_alarm (clr_alarm[g]),
            .alarm_high(alarm_high[g]),
            .alarm_low (alarm_low[g])
        );
    end

    typedef struct {
        int         s;
        logic [3:0] op;
        logic [7:0] opnd;
        int         dr;
        int         dv;
        logic [7:0] d;
        int         hold;
        logic       err;
        logic [7:0] ed;
        int         lat;
        int         iss;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [dut%0d]: got %0h, want %0h", name, s, act, exp);
        end
    endtask

    // Response expected from the timing rules: accept at cycle 0, ready seen dr cycles into
    // the ready wait, valid seen dv cycles into the data wait, each wait bounded by T cycles.
    function automatic void model(input logic [3:0] op, input int dr, input int dv, input int t,
                                  input logic [7:0] d, output logic err, output logic [7:0] ed,
                                  output int lat, output int iss);
        bit rd = (op >= 4 && op <= 7);
        if (dr >= t) begin
            err = 1'b1; ed = 8'h00; lat = 1 + t; iss = 0;
        end else if (!rd) begin
            err = 1'b0; ed = 8'h00; lat = 3 + dr; iss = 1;
        end else if (dv >= t) begin
            err = 1'b1; ed = 8'h00; lat = 3 + dr + t; iss = 1;
        end else begin
            err = 1'b0; ed = d; lat = 4 + dr + dv; iss = 1;
        end
    endfunction

    // Starts at posedge+1 of the accept cycle, returns at posedge+1 of the cycle after the handshake.
    task automatic run_cmd(input int s, input logic [3:0] op, input logic [7:0] opnd, input int dr,
                           input int dv, input logic [7:0] d, input int hold, input logic exp_err,
                           input logic [7:0] exp_data, input int exp_lat, input int exp_iss);
        int ci, iss, rc;
        logic [7:0] d0;
        logic e0;
        req_valid[s] = 1'b1; req_op[s] = op; req_opnd[s] = opnd;
        ready[s] = 1'b0; valid[s] = 1'b0; data[s] = d; rsp_ready[s] = (hold == 0);
        @(negedge clk);
        chk("req_ready_accept", s, req_ready[s], 1'b1);
        chk("rsp_valid_idle", s, rsp_valid[s], 1'b0);
        ci = -1; iss = 0; rc = -1;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk); #1;
            req_valid[s] = 1'b0;
            ready[s] = (c >= 1 + dr);
            valid[s] = (ci >= 0) && (c == ci + 1 + dv);
            @(negedge clk);
            if (op_o[s] != 4'h8) begin
                iss++; ci = c;
                chk("issue_op", s, op_o[s], op);
                chk("issue_opnd", s, opnd_o[s], opnd);
                chk("issue_cycle", s, c, 2 + dr);
            end
            if (rsp_valid[s]) begin
                rc = c;
                break;
            end
        end
        chk("rsp_latency", s, rc, exp_lat);
        chk("rsp_err", s, rsp_err[s], exp_err);
        chk("rsp_data", s, rsp_data[s], exp_data);
        chk("issue_count", s, iss, exp_iss);
        d0 = rsp_data[s]; e0 = rsp_err[s];
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            valid[s] = 1'b0;
            if (h == hold - 1) rsp_ready[s] = 1'b1;
            @(negedge clk);
            chk("rsp_hold_valid", s, rsp_valid[s], 1'b1);
            chk("rsp_hold_data", s, rsp_data[s], d0);
            chk("rsp_hold_err", s, rsp_err[s], e0);
        end
        @(posedge clk); #1;
        rsp_ready[s] = 1'b0; valid[s] = 1'b0; ready[s] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic       e;
        logic [7:0] ed;
        int         lat, iss, s, dr, dv, hold;
        logic [3:0] op;
        logic [7:0] opnd, d;

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 0; req_op[i] = 0; req_opnd[i] = 0; rsp_ready[i] = 0; clr_alarm[i] = 0;
            ready[i] = 0; valid[i] = 0; data[i] = 0; status[i] = ST_OK;
        end

        vecs[0] = '{0, 4'h1, 8'h05, 0, 0,  8'h00, 0, 1'b0, 8'h00, 3, 1};
        vecs[1] = '{0, 4'h4, 8'h00, 0, 4,  8'h3C, 3, 1'b0, 8'h3C, 8, 1};
        vecs[2] = '{1, 4'h2, 8'h11, 10, 0, 8'h00, 0, 1'b1, 8'h00, 5, 0};
        vecs[3] = '{1, 4'h7, 8'h22, 0, 10, 8'hEE, 1, 1'b1, 8'h00, 7, 1};
        vecs[4] = '{1, 4'h5, 8'h33, 0, 3,  8'hA5, 0, 1'b0, 8'hA5, 7, 1};
        vecs[5] = '{1, 4'h1, 8'h44, 3, 0,  8'h00, 0, 1'b0, 8'h00, 6, 1};
        vecs[6] = '{1, 4'hA, 8'h77, 0, 0,  8'h99, 0, 1'b0, 8'h00, 3, 1};
        vecs[7] = '{0, 4'h6, 8'h00, 2, 1,  8'h5A, 1, 1'b0, 8'h5A, 7, 1};
        vecs[8] = '{1, 4'h4, 8'hF0, 2, 0,  8'h01, 2, 1'b0, 8'h01, 6, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_op", i, op_o[i], 4'h8);
            chk("reset_opnd", i, opnd_o[i], 8'h00);
            chk("reset_req_ready", i, req_ready[i], 1'b1);
            chk("reset_rsp_valid", i, rsp_valid[i], 1'b0);
            chk("reset_rsp_data", i, rsp_data[i], 8'h00);
            chk("reset_rsp_err", i, rsp_err[i], 1'b0);
            chk("reset_alarms", i, {alarm_high[i], alarm_low[i]}, 2'b00);
        end
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].s, vecs[i].op, vecs[i].opnd, vecs[i].dr, vecs[i].dv, vecs[i].d,
                    vecs[i].hold, vecs[i].err, vecs[i].ed, vecs[i].lat, vecs[i].iss);
        end

        // Alarms on the TIMEOUT=4 instance
        status[1] = ST_HIGH;
        @(negedge clk);
        chk("alarm_latency", 1, alarm_high[1], 1'b0);
        step(); status[1] = ST_OK;
        @(negedge clk);
        chk("alarm_high_set", 1, alarm_high[1], 1'b1);
        step(); step();
        @(negedge clk);
        chk("alarm_high_sticky", 1, alarm_high[1], 1'b1);
        step(); status[1] = ST_LOW; clr_alarm[1] = 1'b1;
        step(); status[1] = ST_OK; clr_alarm[1] = 1'b0;
        @(negedge clk);
        chk("clr_vs_low", 1, {alarm_high[1], alarm_low[1]}, 2'b01);
        step(); status[1] = ST_HIGH;
        step(); status[1] = ST_OK;
        @(negedge clk);
        chk("alarms_both", 1, {alarm_high[1], alarm_low[1]}, 2'b11);
        step();
        run_cmd(1, 4'h0, 8'h00, 0, 0, 8'h00, 0, 1'b0, 8'h00, 3, 1);
        @(negedge clk);
        chk("reset_cmd_clears", 1, {alarm_high[1], alarm_low[1]}, 2'b00);
        step(); status[1] = ST_LOW;
        step(); status[1] = ST_OK; clr_alarm[1] = 1'b1;
        step(); clr_alarm[1] = 1'b0;
        @(negedge clk);
        chk("clr_alarm_clears", 1, {alarm_high[1], alarm_low[1]}, 2'b00);
        step();

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            s    = $urandom_range(0, 1);
            op   = 4'($urandom_range(0, 15));
            if (op == 4'h8) op = 4'h9;
            opnd = 8'($urandom);
            dr   = $urandom_range(0, 5);
            dv   = $urandom_range(0, 5);
            d    = 8'($urandom);
            hold = $urandom_range(0, 2);
            model(op, dr, dv, (s == 0) ? T0 : T1, d, e, ed, lat, iss);
            run_cmd(s, op, opnd, dr, dv, d, hold, e, ed, lat, iss);
        end

        // Reset in the middle of a read on the TIMEOUT=255 instance
        status[0] = ST_HIGH;
        step(); status[0] = ST_OK;
        req_valid[0] = 1'b1; req_op[0] = 4'h4; req_opnd[0] = 8'h00; ready[0] = 1'b1;
        step(); req_valid[0] = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("pre_reset_alarm", 0, alarm_high[0], 1'b1);
        step(); reset = 1'b1; valid[0] = 1'b1; data[0] = 8'hAA;
        @(negedge clk);
        chk("midreset_op", 0, op_o[0], 4'h8);
        chk("midreset_req_ready", 0, req_ready[0], 1'b1);
        chk("midreset_alarms", 0, {alarm_high[0], alarm_low[0]}, 2'b00);
        step(); reset = 1'b0; valid[0] = 1'b0; ready[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("postreset_no_rsp", 0, rsp_valid[0], 1'b0);
            step();
        end
        @(negedge clk);
        chk("postreset_req_ready", 0, req_ready[0], 1'b1);
        chk("postreset_op", 0, op_o[0], 4'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
